// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file geometry and helpers for the issue scoreboard.
package regfile_scoreboard_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] m;
        m = '0;
        m[addr] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/regfile_scoreboard_hazard_check.sv
// Combinational RAW/WAW/capacity check for one issuing instruction.
module regfile_scoreboard_hazard_check
    import regfile_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic [NUM_REGS-1:0]   eff_busy,
    input  logic [CNT_W-1:0]      outstanding,
    input  logic                  slot_free,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] issue_rs,
    input  logic [REG_ADDR_W-1:0] issue_rt,
    input  logic                  issue_rs_used,
    input  logic                  issue_rt_used,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_wr,
    output logic                  raw_hz,
    output logic                  waw_hz,
    output logic                  issue_ready
);
    logic rd_real;
    logic full_hz;

    always_comb begin
        rd_real = issue_wr && (issue_rd != ZERO_REG);
        raw_hz  = (issue_rs_used && issue_rs != ZERO_REG && eff_busy[issue_rs]) ||
                  (issue_rt_used && issue_rt != ZERO_REG && eff_busy[issue_rt]);
        waw_hz  = rd_real && eff_busy[issue_rd];
        // A writeback retiring in this cycle may hand its slot to the issuer.
        full_hz = rd_real && (outstanding == CNT_W'(MAX_OUTSTANDING)) && !slot_free;
        issue_ready = rst && !flush && !raw_hz && !waw_hz && !full_hz;
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-side scoreboard tracking in-flight register writes and stalling on hazards.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int WB_BYPASS       = 1,
    parameter int CNT_W           = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] issue_rs,
    input  logic [REG_ADDR_W-1:0] issue_rt,
    input  logic                  issue_rs_used,
    input  logic                  issue_rt_used,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_wr,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic                  flush,
    output logic [NUM_REGS-1:0]   busy,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  wb_err,
    output logic [15:0]           stall_cnt
);
    logic [NUM_REGS-1:0] busy_q, busy_d, eff_busy;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wb_err_q, wb_err_d;
    logic [15:0]         stall_q, stall_d;
    logic                wb_clear, slot_free, set_new, raw_hz, waw_hz;

    always_comb begin
        wb_clear  = wb_valid && busy_q[wb_reg];
        slot_free = (WB_BYPASS != 0) && wb_clear;
        eff_busy  = busy_q;
        if (WB_BYPASS != 0 && wb_valid) eff_busy = busy_q & ~reg_mask(wb_reg);
    end

    regfile_scoreboard_hazard_check #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) u_hazard (
        .eff_busy     (eff_busy),
        .outstanding  (cnt_q),
        .slot_free    (slot_free),
        .rst          (rst),
        .flush        (flush),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_rs_used(issue_rs_used),
        .issue_rt_used(issue_rt_used),
        .issue_rd     (issue_rd),
        .issue_wr     (issue_wr),
        .raw_hz       (raw_hz),
        .waw_hz       (waw_hz),
        .issue_ready  (issue_ready)
    );

    always_comb begin
        set_new  = issue_valid && issue_ready && issue_wr && (issue_rd != ZERO_REG);
        busy_d   = busy_q;
        if (wb_clear) busy_d = busy_d & ~reg_mask(wb_reg);
        // Set after clear so a same-register clear+set leaves the bit busy.
        if (set_new)  busy_d = busy_d | reg_mask(issue_rd);
        cnt_d    = cnt_q - CNT_W'(wb_clear) + CNT_W'(set_new);
        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end
        busy_d[0] = 1'b0;
        wb_err_d = wb_err_q || (wb_valid && wb_reg != ZERO_REG && !busy_q[wb_reg]);
        stall_d  = stall_q;
        if (issue_valid && !issue_ready && rst && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q   <= '0;
            cnt_q    <= '0;
            wb_err_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            wb_err_q <= wb_err_d;
            stall_q  <= stall_d;
        end
    end

    assign busy        = busy_q;
    assign outstanding = cnt_q;
    assign wb_err      = wb_err_q;
    assign stall_cnt   = stall_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; a second instance covers the non-bypass writeback timing.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_rs_used, issue_rt_used, issue_wr;
    logic [4:0]  issue_rs, issue_rt, issue_rd, wb_reg;
    logic        wb_valid, flush;
    logic        issue_ready, wb_err;
    logic [31:0] busy;
    logic [2:0]  outstanding;
    logic [15:0] stall_cnt;
    logic        ready0, wb_err0;
    logic [31:0] busy0;
    logic [2:0]  outstanding0;
    logic [15:0] stall_cnt0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.MAX_OUTSTANDING(4), .WB_BYPASS(1), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rs_used(issue_rs_used),
        .issue_rt_used(issue_rt_used), .issue_rd(issue_rd), .issue_wr(issue_wr),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush), .busy(busy),
        .outstanding(outstanding), .wb_err(wb_err), .stall_cnt(stall_cnt)
    );

    regfile_scoreboard #(.MAX_OUTSTANDING(4), .WB_BYPASS(0), .CNT_W(3)) dut0 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(ready0),
        .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rs_used(issue_rs_used),
        .issue_rt_used(issue_rt_used), .issue_rd(issue_rd), .issue_wr(issue_wr),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush), .busy(busy0),
        .outstanding(outstanding0), .wb_err(wb_err0), .stall_cnt(stall_cnt0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs_used = 0; issue_rt_used = 0; issue_wr = 0;
        issue_rs = 0; issue_rt = 0; issue_rd = 0; wb_valid = 0; wb_reg = 0; flush = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        issue_valid = 1; issue_wr = 1; issue_rd = 5;
        tick(); tick();
        n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", issue_ready); end
        n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL reset_busy got %h want 0", busy); end
        n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL reset_out got %0d want 0", outstanding); end
        n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL reset_wberr got %b want 0", wb_err); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        idle();
        rst = 1;
        tick();
    endtask

    task automatic test_basic_issue();
        issue_valid = 1; issue_wr = 1; issue_rd = 5;
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready got %b want 1", issue_ready); end
        tick();
        idle();
        n_cmp++; if (busy !== 32'h20) begin n_bad++; $display("FAIL basic_busy got %h want 00000020", busy); end
        n_cmp++; if (outstanding !== 3'd1) begin n_bad++; $display("FAIL basic_out got %0d want 1", outstanding); end
    endtask

    task automatic test_raw();
        issue_valid = 1; issue_rs = 5; issue_rs_used = 1;
        #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall got %b want 0", issue_ready); end
        tick();
        n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL raw_stallcnt got %0d want 1", stall_cnt); end
        wb_valid = 1; wb_reg = 5;
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL raw_bypass_ready got %b want 1", issue_ready); end
        n_cmp++; if (ready0 !== 1'b0) begin n_bad++; $display("FAIL raw_nobypass_ready got %b want 0", ready0); end
        tick();
        wb_valid = 0; wb_reg = 0;
        #1;
        n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL raw_nobypass_late got %b want 1", ready0); end
        n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL raw_busy got %h want 0", busy); end
        n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL raw_out got %0d want 0", outstanding); end
        tick();
        idle();
        n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL raw_stallcnt2 got %0d want 1", stall_cnt); end
    endtask

    task automatic test_zero();
        issue_valid = 1; issue_wr = 1; issue_rd = 0;
        tick();
        n_cmp++; if (busy !== 32'h0 || outstanding !== 3'd0) begin n_bad++; $display("FAIL zero_rd got %h/%0d want 0/0", busy, outstanding); end
        issue_rd = 3;
        tick();
        issue_rd = 0; issue_rs = 0; issue_rt = 0; issue_rs_used = 1; issue_rt_used = 1;
        wb_valid = 1; wb_reg = 0;
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL zero_src_ready got %b want 1", issue_ready); end
        tick();
        idle();
        n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL zero_wberr got %b want 0", wb_err); end
        n_cmp++; if (busy !== 32'h8 || outstanding !== 3'd1) begin n_bad++; $display("FAIL zero_state got %h/%0d want 00000008/1", busy, outstanding); end
        wb_valid = 1; wb_reg = 3;
        tick();
        idle();
        n_cmp++; if (busy !== 32'h0 || outstanding !== 3'd0) begin n_bad++; $display("FAIL zero_clear got %h/%0d want 0/0", busy, outstanding); end
    endtask

    task automatic test_full();
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1; issue_wr = 1; issue_rd = 5'(r);
            #1;
            n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL full_fill%0d got %b want 1", r, issue_ready); end
            tick();
        end
        n_cmp++; if (outstanding !== 3'd4 || busy !== 32'h1E) begin n_bad++; $display("FAIL full_state got %h/%0d want 0000001e/4", busy, outstanding); end
        issue_rd = 6;
        #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL full_block got %b want 0", issue_ready); end
        tick();
        n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL full_stallcnt got %0d want 2", stall_cnt); end
        issue_wr = 0; issue_rs = 6; issue_rs_used = 1;
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL full_nowrite got %b want 1", issue_ready); end
        issue_wr = 1; issue_rs_used = 0; wb_valid = 1; wb_reg = 1;
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL full_slotfree got %b want 1", issue_ready); end
        tick();
        idle();
        n_cmp++; if (busy !== 32'h5C || outstanding !== 3'd4) begin n_bad++; $display("FAIL full_swap got %h/%0d want 0000005c/4", busy, outstanding); end
    endtask

    task automatic test_same_cycle();
        issue_valid = 1; issue_wr = 1; issue_rd = 4; wb_valid = 1; wb_reg = 4;
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL same_ready got %b want 1", issue_ready); end
        tick();
        idle();
        n_cmp++; if (busy !== 32'h5C || outstanding !== 3'd4) begin n_bad++; $display("FAIL same_state got %h/%0d want 0000005c/4", busy, outstanding); end
        wb_valid = 1; wb_reg = 2;
        tick();
        idle();
        n_cmp++; if (busy !== 32'h58 || outstanding !== 3'd3) begin n_bad++; $display("FAIL same_retire got %h/%0d want 00000058/3", busy, outstanding); end
    endtask

    task automatic test_flush_err();
        flush = 1; issue_valid = 1; issue_wr = 1; issue_rd = 7; wb_valid = 1; wb_reg = 3;
        #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got %b want 0", issue_ready); end
        tick();
        idle();
        n_cmp++; if (busy !== 32'h0 || outstanding !== 3'd0) begin n_bad++; $display("FAIL flush_state got %h/%0d want 0/0", busy, outstanding); end
        n_cmp++; if (stall_cnt !== 16'd3 || wb_err !== 1'b0) begin n_bad++; $display("FAIL flush_kept got %0d/%b want 3/0", stall_cnt, wb_err); end
        wb_valid = 1; wb_reg = 9;
        tick();
        idle();
        n_cmp++; if (wb_err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", wb_err); end
        tick();
        n_cmp++; if (wb_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", wb_err); end
        rst = 0;
        tick();
        rst = 1;
        n_cmp++; if (wb_err !== 1'b0 || stall_cnt !== 16'd0) begin n_bad++; $display("FAIL err_reset got %b/%0d want 0/0", wb_err, stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_raw();
        test_zero();
        test_full();
        test_same_cycle();
        test_flush_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
